// File: rtl/quad2pos.sv
// Quadrature decoder: synchronizes and debounces the A/B phases, then turns
// legal Gray-code steps into an 8-bit position with step, direction and activity flags.
module quad2pos #(
  parameter int FILT      = 4,
  parameter int CLAMP     = 0,
  parameter int IDLE_BITS = 20
) (
  input  logic       clk_sys,
  input  logic       Reset_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       center,
  output logic [7:0] pos,
  output logic       step,
  output logic       dir,
  output logic       active,
  output logic [3:0] err_cnt
);

  localparam logic [3:0]           FILT_CNT   = 4'(FILT);
  localparam logic [IDLE_BITS-1:0] IDLE_LAST  = {{(IDLE_BITS-1){1'b1}}, 1'b0};
  localparam logic [7:0]           POS_CENTER = 8'h80;

  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           cand_q, cand_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           acc_q, acc_d;
  logic                 init_q, init_d;
  logic [7:0]           pos_q, pos_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic                 active_q, active_d;
  logic [IDLE_BITS-1:0] idle_q, idle_d;
  logic [3:0]           err_q, err_d;

  logic       accept;
  logic       tracking;
  logic       is_inc, is_dec, is_ill;
  logic       err_hit;
  logic [1:0] inc_code, dec_code;

  // Candidate tracks the synchronized phases; the count says how long it has been stable.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != FILT_CNT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Neighbours of the accepted state in the Gray cycle 00->01->11->10->00.
  assign inc_code = {acc_q[0], ~acc_q[1]};
  assign dec_code = {~acc_q[0], acc_q[1]};

  assign accept   = (cnt_q == FILT_CNT) && (!init_q || (cand_q != acc_q));
  assign tracking = accept && init_q;
  assign is_inc   = (cand_q == inc_code);
  assign is_dec   = (cand_q == dec_code);
  assign is_ill   = ((acc_q ^ cand_q) == 2'b11);
  assign err_hit  = tracking && is_ill;

  always_comb begin
    acc_d    = acc_q;
    init_d   = init_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    err_d    = err_q;
    active_d = active_q;
    idle_d   = idle_q;

    if (accept) begin
      acc_d  = cand_q;
      init_d = 1'b1;
    end

    if (tracking && (is_inc || is_dec)) begin
      step_d = 1'b1;
      dir_d  = is_inc;
      if (is_inc) begin
        if (!((CLAMP != 0) && (pos_q == 8'hFF))) pos_d = pos_q + 8'd1;
      end else begin
        if (!((CLAMP != 0) && (pos_q == 8'h00))) pos_d = pos_q - 8'd1;
      end
    end

    // Center wins over a simultaneous step; step and dir still report the motion.
    if (center) pos_d = POS_CENTER;

    if (err_hit && (err_q != 4'hF)) err_d = err_q + 4'd1;

    if (step_d) begin
      active_d = 1'b1;
      idle_d   = '0;
    end else if (active_q) begin
      if (idle_q == IDLE_LAST) begin
        active_d = 1'b0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      init_q   <= 1'b0;
      pos_q    <= POS_CENTER;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= '0;
      err_q    <= '0;
    end else begin
      sync1_q  <= {enc_a, enc_b};
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      init_q   <= init_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      active_q <= active_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
    end
  end

  assign pos     = pos_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign active  = active_q;
  assign err_cnt = err_q;

endmodule

// File: doc/quad2pos.md
QUAD2POS -- requirements
Module: quad2pos

Interface
REQ-001 Parameter FILT, default 4, is the number of consecutive stable clocks required to accept a new encoder phase value (legal range 1..15).
REQ-002 Parameter CLAMP, default 0: 0 = position wraps modulo 256; 1 = position saturates at 0 and 255.
REQ-003 Parameter IDLE_BITS, default 20, is the width of the inactivity timer; timeout = 2^IDLE_BITS - 1 clocks.
REQ-004 clk_sys  input  1  sole clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 enc_a  input  1  raw quadrature phase A, asynchronous to clk_sys.
REQ-007 enc_b  input  1  raw quadrature phase B, asynchronous to clk_sys.
REQ-008 center  input  1  synchronous request to load position 8'h80.
REQ-009 pos  output  8  accumulated position.
REQ-010 step  output  1  one-cycle pulse per accepted legal transition.
REQ-011 dir  output  1  direction of the last step: 1 = increment, 0 = decrement.
REQ-012 active  output  1  encoder activity flag, used to select the encoder over the joystick emulation.
REQ-013 err_cnt  output  4  saturating count of illegal (double-bit) transitions.

Function
REQ-014 enc_a and enc_b SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Filter: a synchronized {A,B} value that differs from the accepted state SHALL become the accepted state only after it has been identical on FILT consecutive clocks; any change in the candidate value SHALL restart the count.
REQ-016 Latency: step SHALL assert exactly FILT+3 clocks after the first edge that samples a stable new raw value.
REQ-017 Init: the first value accepted after reset SHALL load the accepted state without producing step, a pos change, or an error.
REQ-018 Increment sequence {A,B}: 00->01->11->10->00; each such transition SHALL pulse step with dir=1 and add 1 to pos.
REQ-019 Decrement: the reverse sequence SHALL pulse step with dir=0 and subtract 1 from pos.
REQ-020 Illegal transition (both bits change in one accepted update): accepted state updates; no step; pos and dir unchanged; err_cnt increments and saturates at 15.
REQ-021 CLAMP=0: 255+1 -> 0 and 0-1 -> 255.
REQ-022 CLAMP=1: 255+1 stays 255 and 0-1 stays 0; step and dir still pulse.
REQ-023 center: pos <= 8'h80 on the next edge; center has priority over a simultaneous step (the step pulse and dir still occur, but pos = 8'h80).
REQ-024 active: set on the edge on which step asserts; idle timer cleared on every step.
REQ-025 The idle timer SHALL increment while active=1 and no step occurs; on reaching 2^IDLE_BITS-1 it SHALL clear active and reset the timer to 0.
REQ-026 Illegal transitions SHALL NOT set active and SHALL NOT reset the idle timer.
REQ-027 step SHALL never be high on two consecutive clocks.

Reset
REQ-028 While Reset_n=0: pos=8'h80, step=0, dir=0, active=0, err_cnt=0; synchronizers, filter counter, idle timer and init flag are cleared.
REQ-029 Reset assertion mid-filter or mid-count SHALL abandon the pending value; after release, REQ-017 applies again.

Verification
REQ-030 Reset, then hold {A,B}=00 for 10 clocks -> no step; pos=8'h80; active=0.
REQ-031 FILT=4: drive 00,01,11,10,00 with each value held 8 clocks -> 4 step pulses, dir=1, pos=8'h84, active=1; first step 7 clocks after the first sampling edge.
REQ-032 A 2-clock glitch 00->01->00 (shorter than FILT) -> no step; pos unchanged.
REQ-033 CLAMP=0: pos=8'hFF, one increment -> pos=8'h00. CLAMP=1: pos=8'h00, one decrement -> pos=8'h00, with step=1 and dir=0.
REQ-034 Jump 00->11, then 17 further illegal jumps -> err_cnt=15 (saturated); pos unchanged; no step.
REQ-035 IDLE_BITS=4: one step, then no activity -> active falls 15 clocks after the step; center asserted in the same clock as a step -> pos=8'h80.
